// File: rtl/bloom_filter_unit.sv
// rtl/bloom_filter_unit.sv - multi-cycle Bloom-filter coprocessor (insert/check/clear/count)
// Optional hit counter and opcode 00110 enabled by `define BLOOM_STATS_EN.
module bloom_filter_unit #(
  parameter int M_BITS = 256,
  parameter int K_HASH = 3,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        custom_en,
  input  logic [4:0]  custom_op_ex,
  input  logic [31:0] custom_in_RS1,
  output logic        custom_busy,
  output logic        custom_valid,
  output logic [31:0] custom_result,
  output logic        custom_err
);

  localparam int IDX_W  = $clog2(M_BITS);
  localparam int WORDS  = M_BITS / 32;
  localparam int WA_W   = IDX_W - 5;
  localparam int NCHUNK = (32 + IDX_W - 1) / IDX_W;

  localparam logic [4:0] OP_INSERT = 5'b00001;
  localparam logic [4:0] OP_CLEAR  = 5'b00011;
  localparam logic [4:0] OP_CHECK  = 5'b00100;
  localparam logic [4:0] OP_COUNT  = 5'b00101;
  localparam logic [4:0] OP_HITS   = 5'b00110;

  typedef enum logic [2:0] {S_IDLE, S_INSERT, S_CHECK, S_CLEAR, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_mem [WORDS];
  logic [31:0]       r_key;
  logic [3:0]        r_i;
  logic [WA_W-1:0]   r_w;
  logic              r_new;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_result;
  logic              r_err;
  logic [IDX_W-1:0]  w_idx;
  logic [WA_W-1:0]   w_word;
  logic [4:0]        w_bitpos;
  logic [31:0]       w_rd;
  logic              w_bit;
  logic              w_last;
`ifdef BLOOM_STATS_EN
  logic [CNT_W-1:0]  r_hits;
`endif

  // Rotate, whiten with a per-hash golden-ratio multiple, then fold to IDX_W bits.
  function automatic logic [IDX_W-1:0] hash_idx(input logic [31:0] key, input int i);
    logic [4:0]       sh;
    logic [31:0]      k;
    logic [IDX_W-1:0] acc;
    sh  = 5'(7 * i);
    k   = (key << sh) | (key >> (6'd32 - {1'b0, sh}));
    k   = k ^ (32'h9E3779B9 * 32'(i + 1));
    acc = '0;
    for (int c = 0; c < NCHUNK; c++) acc = acc ^ IDX_W'(k >> (c * IDX_W));
    return acc;
  endfunction

  always_comb begin
    w_idx    = hash_idx(r_key, int'(r_i));
    w_word   = w_idx[IDX_W-1:5];
    w_bitpos = w_idx[4:0];
    w_rd     = r_mem[w_word];
    w_bit    = w_rd[w_bitpos];
    w_last   = (r_i == 4'(K_HASH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    custom_busy  = 1'b0;
    custom_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (custom_en) begin
          case (custom_op_ex)
            OP_INSERT: w_next = S_INSERT;
            OP_CHECK:  w_next = S_CHECK;
            OP_CLEAR:  w_next = S_CLEAR;
            default:   w_next = S_DONE;
          endcase
        end
      end
      S_INSERT: begin
        custom_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_CHECK: begin
        custom_busy = 1'b1;
        if (!w_bit || w_last) w_next = S_DONE;
      end
      S_CLEAR: begin
        custom_busy = 1'b1;
        if (r_w == '1) w_next = S_DONE;
      end
      S_DONE: begin
        custom_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Result/err only change on the edge that enters DONE, so they hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < WORDS; n++) r_mem[n] <= '0;
      r_key    <= '0;
      r_i      <= '0;
      r_w      <= '0;
      r_new    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
`ifdef BLOOM_STATS_EN
      r_hits   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (custom_en) begin
            r_key <= custom_in_RS1;
            r_i   <= '0;
            r_w   <= '0;
            r_new <= 1'b0;
            case (custom_op_ex)
              OP_INSERT, OP_CHECK, OP_CLEAR: ;
              OP_COUNT: begin
                r_result <= 32'(r_cnt);
                r_err    <= 1'b0;
              end
`ifdef BLOOM_STATS_EN
              OP_HITS: begin
                r_result <= 32'(r_hits);
                r_err    <= 1'b0;
              end
`endif
              default: begin
                r_result <= '0;
                r_err    <= 1'b1;
              end
            endcase
          end
        end
        S_INSERT: begin
          r_mem[w_word] <= w_rd | (32'd1 << w_bitpos);
          r_i           <= r_i + 4'd1;
          if (!w_bit) r_new <= 1'b1;
          if (w_last) begin
            r_result <= {31'd0, !r_new && w_bit};
            r_err    <= 1'b0;
            if ((r_new || !w_bit) && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          r_i <= r_i + 4'd1;
          if (!w_bit) begin
            r_result <= '0;
            r_err    <= 1'b0;
          end else if (w_last) begin
            r_result <= 32'd1;
            r_err    <= 1'b0;
`ifdef BLOOM_STATS_EN
            if (r_hits != '1) r_hits <= r_hits + CNT_W'(1);
`endif
          end
        end
        S_CLEAR: begin
          r_mem[r_w] <= '0;
          r_w        <= r_w + WA_W'(1);
          if (r_w == '1) begin
            r_result <= '0;
            r_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign custom_result = r_result;
  assign custom_err    = r_err;

endmodule

// File: tb/tb_bloom_filter_unit.sv
// tb/tb_bloom_filter_unit.sv - randomized scoreboard bench for bloom_filter_unit
module tb_bloom_filter_unit;

  localparam int M_BITS = 256;
  localparam int K_HASH = 3;
  localparam int CNT_W  = 6;
  localparam int IDX_W  = 8;
  localparam int WORDS  = M_BITS / 32;
  localparam int SAT    = (1 << CNT_W) - 1;

  localparam logic [4:0] INS = 5'b00001;
  localparam logic [4:0] CLR = 5'b00011;
  localparam logic [4:0] CHK = 5'b00100;
  localparam logic [4:0] CNT = 5'b00101;
  localparam logic [4:0] HIT = 5'b00110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [4:0]  op  = '0;
  logic [31:0] rs1 = '0;
  logic        busy, valid, err;
  logic [31:0] result;

  always #5 clk = ~clk;

  bloom_filter_unit #(.M_BITS(M_BITS), .K_HASH(K_HASH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .custom_en(en), .custom_op_ex(op), .custom_in_RS1(rs1),
    .custom_busy(busy), .custom_valid(valid), .custom_result(result), .custom_err(err)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          acc;
    logic [4:0]  op;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   model_arr [M_BITS];
  int   m_cnt = 0;
  int   m_hits = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int tb_idx(input logic [31:0] key, input int i);
    logic [63:0] kk;
    logic [31:0] k;
    logic [31:0] acc;
    kk  = {key, key} << ((7 * i) % 32);
    k   = kk[63:32] ^ (32'h9E3779B9 * 32'(i + 1));
    acc = '0;
    for (int c = 0; c * IDX_W < 32; c++) acc = acc ^ ((k >> (c * IDX_W)) & 32'(M_BITS - 1));
    return int'(acc);
  endfunction

  task automatic model(input logic [4:0] o, input logic [31:0] key, output exp_t e);
    bit all;
    int j;
    e.res = '0; e.err = 1'b0; e.lat = 1; e.op = o; e.acc = 0;
    case (o)
      INS: begin
        all = 1'b1;
        for (int i = 0; i < K_HASH; i++) if (!model_arr[tb_idx(key, i)]) all = 1'b0;
        for (int i = 0; i < K_HASH; i++) model_arr[tb_idx(key, i)] = 1'b1;
        if (!all && m_cnt < SAT) m_cnt++;
        e.res = 32'(all);
        e.lat = K_HASH + 1;
      end
      CHK: begin
        j = K_HASH;
        for (int i = K_HASH - 1; i >= 0; i--) if (!model_arr[tb_idx(key, i)]) j = i;
        if (j == K_HASH) begin
          e.res = 32'd1;
          e.lat = K_HASH + 1;
          if (m_hits < SAT) m_hits++;
        end else begin
          e.lat = j + 2;
        end
      end
      CLR: begin
        for (int b = 0; b < M_BITS; b++) model_arr[b] = 1'b0;
        e.lat = WORDS + 1;
      end
      CNT: e.res = 32'(m_cnt);
`ifdef BLOOM_STATS_EN
      HIT: e.res = 32'(m_hits);
`endif
      default: e.err = 1'b1;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk($sformatf("result_op%05b", e.op), result, e.res);
        chk($sformatf("err_op%05b", e.op), {31'd0, err}, {31'd0, e.err});
        chk($sformatf("latency_op%05b", e.op), 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("busy_at_valid", {31'd0, busy}, 32'd0);
      end
      done_cnt++;
    end
  end

  task automatic issue(input logic [4:0] o, input logic [31:0] key);
    exp_t e;
    int   n;
    int   guard;
    guard = 0;
    while ((busy || valid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    model(o, key, e);
    e.acc = cyc + 1;
    q.push_back(e);
    n   = done_cnt;
    en  = 1'b1;
    op  = o;
    rs1 = key;
    @(posedge clk);
    #1;
    en  = 1'b0;
    rs1 = $urandom;
    guard = 0;
    while (done_cnt == n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (done_cnt == n) begin
      chk("completion_timeout", 32'd0, 32'd1);
      q.delete();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pool [8];
    logic [31:0] key;
    logic [4:0]  iop;
    int          r;

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(CHK, 32'h12345678);
    issue(CNT, 32'h0);
    issue(INS, 32'hDEADBEEF);
    issue(CHK, 32'hDEADBEEF);
    issue(CNT, 32'h0);
    issue(INS, 32'hDEADBEEF);
    issue(CNT, 32'h0);
    issue(INS, 32'hCAFEF00D);
    issue(CLR, 32'h0);
    issue(CHK, 32'hCAFEF00D);
    issue(CNT, 32'h0);

    fork
      issue(INS, 32'h0BADF00D);
      begin
        repeat (2) @(negedge clk);
        en = 1'b1;
        op = CLR;
        @(negedge clk);
        en = 1'b0;
      end
    join
    issue(CHK, 32'h0BADF00D);
    issue(5'b11111, 32'h0);
    issue(HIT, 32'h0);

    for (int n = 0; n < 8; n++) pool[n] = $urandom;
    for (int n = 0; n < 300; n++) begin
      r   = $urandom_range(0, 99);
      key = pool[$urandom_range(0, 7)];
      if (r < 40)      issue(INS, key);
      else if (r < 75) issue(CHK, (r % 2 == 0) ? key : $urandom);
      else if (r < 85) issue(CNT, 32'h0);
      else if (r < 90) issue(CLR, 32'h0);
      else if (r < 95) issue(HIT, 32'h0);
      else begin
        iop = 5'($urandom_range(0, 31));
        if (iop == INS || iop == CLR || iop == CHK || iop == CNT || iop == HIT) iop = 5'b11111;
        issue(iop, key);
      end
    end

    for (int n = 0; n < 140; n++) begin
      if (n % 6 == 5) issue(CLR, 32'h0);
      else            issue(INS, $urandom);
    end
    issue(CNT, 32'h0);
    issue(INS, $urandom);
    issue(CNT, 32'h0);

    while (busy || valid) @(negedge clk);
    en = 1'b1;
    op = CLR;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midclear_rst_busy", {31'd0, busy}, 32'd0);
    chk("midclear_rst_valid", {31'd0, valid}, 32'd0);
    chk("midclear_rst_result", result, 32'd0);
    chk("midclear_rst_err", {31'd0, err}, 32'd0);
    for (int b = 0; b < M_BITS; b++) model_arr[b] = 1'b0;
    m_cnt  = 0;
    m_hits = 0;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(CNT, 32'h0);
    issue(HIT, 32'h0);
    issue(CHK, 32'hDEADBEEF);
    issue(INS, 32'hDEADBEEF);
    issue(CNT, 32'h0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
